// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD load arbiter.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned HOLD_W  = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_LOAD  = 2'd2,
        ST_HOLD  = 2'd3
    } arb_state_t;

    // True when the digit is a legal BCD value (0..9).
    function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the side
// that did not win last time. No requests yields winner 0 (don't care).
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_src,
    output logic winner
);

    // Tie resolves away from the previous winner.
    always_comb begin
        winner = req1;
        if (req0 && req1) begin
            winner = ~last_src;
        end
    end

endmodule

// File: rtl/bcd_load_arbiter.sv
// Shares the BCD counter parallel-load port between two requesters.
// Round-robin grant, one-cycle Load strobe, programmable hold-off.
// Optional digit validation is enabled by defining BCD_ARB_VALIDATE_EN.
module bcd_load_arbiter
    import bcd_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic [DIGIT_W-1:0] din0,
    input  logic               req1,
    input  logic [DIGIT_W-1:0] din1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               Load,
    output logic [DIGIT_W-1:0] Din,
    output logic               busy,
    output logic               last_src
`ifdef BCD_ARB_VALIDATE_EN
    ,
    output logic               err
`endif
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_CYCLES);
    localparam logic              NO_HOLD  = (HOLD_CYCLES == 0);

    arb_state_t         state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               granted_q, granted_d;
    logic               ptr_c;
    logic               win_c;
    logic [DIGIT_W-1:0] pick_c;
    logic               hold_done_c;

    logic               gnt0_d, gnt1_d, load_d, busy_d, src_d;
    logic [DIGIT_W-1:0] din_d;

`ifdef BCD_ARB_VALIDATE_EN
    logic               bad_q, bad_d;
    logic               err_d;
`endif

    // Until the first grant the pointer favours requester 0.
    assign ptr_c  = granted_q ? last_src : 1'b1;
    assign pick_c = win_c ? din1 : din0;
    assign hold_done_c = (5'(hold_cnt_q) + 5'd1) >= 5'(HOLD_CYCLES);

    rr_arb2 u_rr (
        .req0     (req0),
        .req1     (req1),
        .last_src (ptr_c),
        .winner   (win_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                state_d = ST_LOAD;
`ifdef BCD_ARB_VALIDATE_EN
                if (bad_q) begin
                    state_d = NO_HOLD ? ST_IDLE : ST_HOLD;
                end
`endif
            end
            ST_LOAD: begin
                state_d = NO_HOLD ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_done_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, hold counter and grant flags.
    always_comb begin
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        load_d     = 1'b0;
        din_d      = Din;
        src_d      = last_src;
        granted_d  = granted_q;
        busy_d     = (state_d != ST_IDLE);
        hold_cnt_d = '0;
`ifdef BCD_ARB_VALIDATE_EN
        bad_d      = 1'b0;
        err_d      = 1'b0;
`endif

        if (state_q == ST_IDLE && state_d == ST_GRANT) begin
            gnt0_d    = ~win_c;
            gnt1_d    = win_c;
            src_d     = win_c;
            granted_d = 1'b1;
`ifdef BCD_ARB_VALIDATE_EN
            if (is_bcd(pick_c)) begin
                din_d = pick_c;
            end else begin
                bad_d = 1'b1;
                err_d = 1'b1;
            end
`else
            din_d = pick_c;
`endif
        end

        if (state_d == ST_LOAD) begin
            load_d = 1'b1;
        end

        // Saturating hold counter, restarted on every entry to HOLD.
        if (state_q == ST_HOLD && state_d == ST_HOLD) begin
            hold_cnt_d = (hold_cnt_q < HOLD_LIM) ? hold_cnt_q + HOLD_W'(1) : hold_cnt_q;
        end
    end

    // Output and datapath registers; reset clears any load in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            Load       <= 1'b0;
            Din        <= '0;
            busy       <= 1'b0;
            last_src   <= 1'b0;
            granted_q  <= 1'b0;
            hold_cnt_q <= '0;
`ifdef BCD_ARB_VALIDATE_EN
            bad_q      <= 1'b0;
            err        <= 1'b0;
`endif
        end else begin
            gnt0       <= gnt0_d;
            gnt1       <= gnt1_d;
            Load       <= load_d;
            Din        <= din_d;
            busy       <= busy_d;
            last_src   <= src_d;
            granted_q  <= granted_d;
            hold_cnt_q <= hold_cnt_d;
`ifdef BCD_ARB_VALIDATE_EN
            bad_q      <= bad_d;
            err        <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_bcd_load_arbiter.sv
// Scoreboard bench for bcd_load_arbiter: dut_a uses HOLD_CYCLES=2, dut_b uses 0.
module tb_bcd_load_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_req0 = 0, a_req1 = 0;
    logic [3:0] a_din0 = 0, a_din1 = 0;
    logic       a_gnt0, a_gnt1, a_load, a_busy, a_last_src;
    logic [3:0] a_din;
    logic       b_req0 = 0, b_req1 = 0;
    logic [3:0] b_din0 = 0, b_din1 = 0;
    logic       b_gnt0, b_gnt1, b_load, b_busy, b_last_src;
    logic [3:0] b_din;
`ifdef BCD_ARB_VALIDATE_EN
    logic       a_err, b_err;
`endif

    bcd_load_arbiter #(.HOLD_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0(a_req0), .din0(a_din0), .req1(a_req1), .din1(a_din1),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .Load(a_load), .Din(a_din),
        .busy(a_busy), .last_src(a_last_src)
`ifdef BCD_ARB_VALIDATE_EN
        , .err(a_err)
`endif
    );

    bcd_load_arbiter #(.HOLD_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .din0(b_din0), .req1(b_req1), .din1(b_din1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .Load(b_load), .Din(b_din),
        .busy(b_busy), .last_src(b_last_src)
`ifdef BCD_ARB_VALIDATE_EN
        , .err(b_err)
`endif
    );

    typedef struct {
        logic [3:0] din;
        logic       src;
        int         cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_a(input logic [3:0] d, input logic s, input int c);
        exp_t e;
        e.din = d; e.src = s; e.cyc = c;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [3:0] d, input logic s, input int c);
        exp_t e;
        e.din = d; e.src = s; e.cyc = c;
        qb.push_back(e);
    endtask

    // Monitor: every Load pops the expected digit, source and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("a_excl", 32'({a_gnt0 & a_gnt1, a_load & (a_gnt0 | a_gnt1)}), 32'd0);
            chk("b_excl", 32'({b_gnt0 & b_gnt1, b_load & (b_gnt0 | b_gnt1)}), 32'd0);
            if (a_load) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_load", 32'd1, 32'd0);
                end else begin
                    e = qa.pop_front();
                    chk("a_load_din", 32'(a_din), 32'(e.din));
                    chk("a_load_src", 32'(a_last_src), 32'(e.src));
                    chk("a_load_cyc", 32'(cyc), 32'(e.cyc));
                end
            end
            if (b_load) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_load", 32'd1, 32'd0);
                end else begin
                    e = qb.pop_front();
                    chk("b_load_din", 32'(b_din), 32'(e.din));
                    chk("b_load_src", 32'(b_last_src), 32'(e.src));
                    chk("b_load_cyc", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        int d;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt0", 32'(a_gnt0), 32'd0);
        chk("rst_gnt1", 32'(a_gnt1), 32'd0);
        chk("rst_load", 32'(a_load), 32'd0);
        chk("rst_din", 32'(a_din), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_last_src", 32'(a_last_src), 32'd0);
        chk("rst_b_busy", 32'(b_busy), 32'd0);
`ifdef BCD_ARB_VALIDATE_EN
        chk("rst_err", 32'(a_err), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Both requesting from reset: 0 wins first, then 1, five cycles apart.
        d = cyc;
        a_req0 = 1; a_din0 = 4'd3; a_req1 = 1; a_din1 = 4'd7;
        push_a(4'd3, 1'b0, d + 2);
        push_a(4'd7, 1'b1, d + 7);
        @(negedge clk);
        chk("tie_gnt0", 32'(a_gnt0), 32'd1);
        chk("tie_gnt1_first", 32'(a_gnt1), 32'd0);
        chk("tie_busy", 32'(a_busy), 32'd1);
        a_req0 = 0;
        @(negedge clk);
        chk("tie_load0", 32'(a_load), 32'd1);
        repeat (3) @(negedge clk);
        chk("tie_gnt1_wait", 32'(a_gnt1), 32'd0);
        @(negedge clk);
        chk("tie_gnt1", 32'(a_gnt1), 32'd1);
        chk("tie_gnt0_second", 32'(a_gnt0), 32'd0);
        a_req1 = 0;
        repeat (4) @(negedge clk);
        chk("tie_idle_busy", 32'(a_busy), 32'd0);
        chk("tie_last_src", 32'(a_last_src), 32'd1);

        // Single req0 digit 5, then req1 raised during HOLD.
        d = cyc;
        a_req0 = 1; a_din0 = 4'd5;
        push_a(4'd5, 1'b0, d + 2);
        @(negedge clk);
        chk("single_gnt0", 32'(a_gnt0), 32'd1);
        chk("single_busy", 32'(a_busy), 32'd1);
        a_req0 = 0;
        @(negedge clk);
        chk("single_load", 32'(a_load), 32'd1);
        chk("single_din", 32'(a_din), 32'd5);
        @(negedge clk);
        a_req1 = 1; a_din1 = 4'd2;
        push_a(4'd2, 1'b1, d + 7);
        @(negedge clk);
        chk("hold_no_gnt1", 32'(a_gnt1), 32'd0);
        chk("hold_busy", 32'(a_busy), 32'd1);
        @(negedge clk);
        chk("idle_busy", 32'(a_busy), 32'd0);
        chk("idle_no_gnt1", 32'(a_gnt1), 32'd0);
        @(negedge clk);
        chk("late_gnt1", 32'(a_gnt1), 32'd1);
        a_req1 = 0;
        repeat (4) @(negedge clk);
        chk("late_idle", 32'(a_busy), 32'd0);

        // Reset pulled in the LOAD cycle.
        d = cyc;
        a_req0 = 1; a_din0 = 4'd9;
        push_a(4'd9, 1'b0, d + 2);
        @(negedge clk);
        chk("rl_gnt0", 32'(a_gnt0), 32'd1);
        a_req0 = 0;
        @(negedge clk);
        chk("rl_load_pre", 32'(a_load), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rl_load_async", 32'(a_load), 32'd0);
        chk("rl_busy_async", 32'(a_busy), 32'd0);
        chk("rl_din_async", 32'(a_din), 32'd0);
        chk("rl_src_async", 32'(a_last_src), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rl_post_busy", 32'(a_busy), 32'd0);
        chk("rl_post_src", 32'(a_last_src), 32'd0);
        chk("rl_post_load", 32'(a_load), 32'd0);

        // HOLD_CYCLES=0 with req0 held: a load every 3 cycles.
        d = cyc;
        b_req0 = 1; b_din0 = 4'd6;
        for (int i = 0; i < 4; i++) push_b(4'd6, 1'b0, d + 2 + 3 * i);
        repeat (10) @(negedge clk);
        b_req0 = 0;
        repeat (4) @(negedge clk);
        chk("b_idle_busy", 32'(b_busy), 32'd0);
        chk("b_last_src", 32'(b_last_src), 32'd0);

`ifdef BCD_ARB_VALIDATE_EN
        // Good digit 4, then illegal 4'hC: err with gnt, no Load, Din kept.
        d = cyc;
        a_req0 = 1; a_din0 = 4'd4;
        push_a(4'd4, 1'b0, d + 2);
        @(negedge clk);
        a_req0 = 0;
        repeat (4) @(negedge clk);
        a_req0 = 1; a_din0 = 4'hC;
        @(negedge clk);
        chk("val_gnt0", 32'(a_gnt0), 32'd1);
        chk("val_err", 32'(a_err), 32'd1);
        a_req0 = 0;
        @(negedge clk);
        chk("val_no_load", 32'(a_load), 32'd0);
        chk("val_err_drop", 32'(a_err), 32'd0);
        chk("val_din_kept", 32'(a_din), 32'd4);
        repeat (2) @(negedge clk);
        chk("val_idle", 32'(a_busy), 32'd0);
        chk("val_last_src", 32'(a_last_src), 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("a_queue_empty", 32'(qa.size()), 32'd0);
        chk("b_queue_empty", 32'(qb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
